// File: rtl/jtdsp16_loop_cache_pkg.sv
// Shared definitions for the DSP16 do/redo loop cache: sizes, FSM states and do_data field layout.
package jtdsp16_loop_cache_pkg;
    localparam int LC_DEPTH = 15;
    localparam int LC_KW    = 4;
    localparam int LC_NW    = 7;

    localparam int DO_N_MSB = 10;
    localparam int DO_N_LSB = 4;
    localparam int DO_K_MSB = 3;
    localparam int DO_K_LSB = 0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RECORD = 2'd1,
        ST_REPLAY = 2'd2
    } lc_state_t;
endpackage

// File: rtl/jtdsp16_loop_cache_if.sv
// Control/instruction bus between jtdsp16_ctrl (master) and the loop cache sequencer (slave).
interface jtdsp16_loop_cache_if;
    logic        do_start;
    logic        redo_start;
    logic [10:0] do_data;
    logic        inst_issue;
    logic [15:0] rom_dout;
    logic [15:0] cache_dout;
    logic        cache_sel;
    logic        pc_halt;
    logic        no_int;
    logic        busy;

    modport master (
        output do_start, redo_start, do_data, inst_issue, rom_dout,
        input  cache_dout, cache_sel, pc_halt, no_int, busy
    );
    modport slave (
        input  do_start, redo_start, do_data, inst_issue, rom_dout,
        output cache_dout, cache_sel, pc_halt, no_int, busy
    );
endinterface

// File: rtl/jtdsp16_cache_mem.sv
// DEPTH x 16 loop-body register file: one synchronous write port, one asynchronous read port.
module jtdsp16_cache_mem #(
    parameter int DEPTH = 15,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [15:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [15:0]   rdata
);
    logic [15:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we && int'(waddr) < DEPTH) mem[waddr] <= wdata;
    end

    // Pointer space may be wider than DEPTH; unused addresses read as zero
    assign rdata = (int'(raddr) < DEPTH) ? mem[raddr] : 16'h0000;
endmodule

// File: rtl/jtdsp16_loop_cache.sv
// do/redo sequencer: records K body words from ROM, then replays them from the cache with the PC held.
module jtdsp16_loop_cache
    import jtdsp16_loop_cache_pkg::*;
#(
    parameter int DEPTH = LC_DEPTH,
    parameter int KW    = LC_KW,
    parameter int NW    = LC_NW
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cen,
    jtdsp16_loop_cache_if.slave     bus
);
    lc_state_t         state;
    logic [KW-1:0]     k_reg, wr_ptr, rd_ptr, k_field, k_in, k_last;
    logic [NW-1:0]     n_cnt, n_in;
    logic              cache_we;

    assign k_field = KW'(bus.do_data[DO_K_MSB:DO_K_LSB]);
    assign k_in    = (int'(k_field) > DEPTH) ? KW'(DEPTH) : k_field;
    assign n_in    = NW'(bus.do_data[DO_N_MSB:DO_N_LSB]);
    assign k_last  = k_reg - KW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            k_reg  <= '0;
            n_cnt  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (cen) begin
            case (state)
                ST_IDLE: begin
                    if (bus.do_start && k_in != '0 && n_in != '0) begin
                        k_reg  <= k_in;
                        n_cnt  <= n_in;
                        wr_ptr <= '0;
                        state  <= ST_RECORD;
                    end else if (bus.redo_start && k_reg != '0 && n_in != '0) begin
                        n_cnt  <= n_in;
                        rd_ptr <= '0;
                        state  <= ST_REPLAY;
                    end
                end
                ST_RECORD: begin
                    if (bus.inst_issue) begin
                        wr_ptr <= wr_ptr + KW'(1);
                        if (wr_ptr == k_last) begin
                            if (n_cnt == NW'(1)) begin
                                state <= ST_IDLE;
                            end else begin
                                n_cnt  <= n_cnt - NW'(1);
                                rd_ptr <= '0;
                                state  <= ST_REPLAY;
                            end
                        end
                    end
                end
                ST_REPLAY: begin
                    if (bus.inst_issue) begin
                        if (rd_ptr == k_last) begin
                            rd_ptr <= '0;
                            if (n_cnt == NW'(1)) state <= ST_IDLE;
                            else                 n_cnt <= n_cnt - NW'(1);
                        end else begin
                            rd_ptr <= rd_ptr + KW'(1);
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Only the body fetch from ROM lands in the cache
    assign cache_we = cen && bus.inst_issue && (state == ST_RECORD);

    jtdsp16_cache_mem #(.DEPTH(DEPTH), .AW(KW)) u_mem (
        .clk   (clk),
        .we    (cache_we),
        .waddr (wr_ptr),
        .wdata (bus.rom_dout),
        .raddr (rd_ptr),
        .rdata (bus.cache_dout)
    );

    assign bus.busy      = (state != ST_IDLE);
    assign bus.no_int    = (state != ST_IDLE);
    assign bus.cache_sel = (state == ST_REPLAY);
    assign bus.pc_halt   = (state == ST_REPLAY);
endmodule

// File: tb/tb_jtdsp16_loop_cache.sv
// Bench for jtdsp16_loop_cache: issue-counting loop model plus directed and random do/redo traffic.
module tb_jtdsp16_loop_cache;
    logic clk = 1'b0;
    logic rst, cen;
    int   checks = 0, failures = 0;
    bit   chk_en = 1'b0;
    int   sel_issues;

    jtdsp16_loop_cache_if lc();
    jtdsp16_loop_cache dut (.clk(clk), .rst(rst), .cen(cen), .bus(lc));

    always #5 clk = ~clk;

    // Model: a loop is K*N issues; the first `m_rec` come from ROM, the rest cycle through the body
    bit          m_active = 1'b0;
    int          m_k = 0, m_total = 0, m_rec = 0, m_idx = 0;
    logic [15:0] m_body [15];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit m_sel();
        return m_active && (m_idx >= m_rec);
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", 32'(lc.busy), 32'(m_active));
            chk("no_int", 32'(lc.no_int), 32'(m_active));
            chk("cache_sel", 32'(lc.cache_sel), 32'(m_sel()));
            chk("pc_halt", 32'(lc.pc_halt), 32'(m_sel()));
            if (m_sel())
                chk("cache_dout", 32'(lc.cache_dout), 32'(m_body[(m_idx - m_rec) % m_k]));
        end
    end

    task automatic model(input bit d, input bit r, input logic [10:0] dd, input bit iss,
                         input logic [15:0] rw, input bit c, input bit rs);
        int kin, nin;
        kin = int'(dd[3:0]);
        nin = int'(dd[10:4]);
        if (kin > 15) kin = 15;
        if (rs) begin
            m_active = 1'b0;
            m_k      = 0;
        end else if (c) begin
            if (!m_active) begin
                if (d && kin != 0 && nin != 0) begin
                    m_active = 1'b1; m_k = kin; m_total = kin * nin; m_rec = kin; m_idx = 0;
                end else if (r && m_k != 0 && nin != 0) begin
                    m_active = 1'b1; m_total = m_k * nin; m_rec = 0; m_idx = 0;
                end
            end else if (iss) begin
                if (m_idx < m_rec) m_body[m_idx] = rw;
                m_idx++;
                if (m_idx == m_total) m_active = 1'b0;
            end
        end
    endtask

    // Drive at negedge, let the DUT sample at posedge, update the model, return at the next negedge
    task automatic step(input bit d, input bit r, input logic [10:0] dd, input bit iss,
                        input logic [15:0] rw, input bit c, input bit rs);
        lc.do_start = d; lc.redo_start = r; lc.do_data = dd;
        lc.inst_issue = iss; lc.rom_dout = rw; cen = c; rst = rs;
        if (iss && c && lc.cache_sel) sel_issues++;
        @(posedge clk);
        model(d, r, dd, iss, rw, c, rs);
        @(negedge clk);
    endtask

    function automatic logic [10:0] dw(input int n, input int k);
        return {7'(n), 4'(k)};
    endfunction

    task automatic issue(input logic [15:0] rw);
        step(0, 0, 11'd0, 1, rw, 1, 0);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (lc.busy && n < budget) begin
            issue(16'($urandom));
            n++;
        end
        chk("drain_timeout", 32'(lc.busy), 32'(0));
    endtask

    logic [15:0] lit [3];

    initial begin
        lit[0] = 16'h1111; lit[1] = 16'h2222; lit[2] = 16'h3333;
        lc.do_start = 0; lc.redo_start = 0; lc.do_data = '0;
        lc.inst_issue = 0; lc.rom_dout = '0; cen = 0; rst = 1;
        @(negedge clk);
        step(0, 0, 11'd0, 0, 16'h0, 1, 1);
        chk_en = 1'b1;
        chk("reset_busy", 32'({lc.busy, lc.no_int, lc.cache_sel, lc.pc_halt}), 32'(0));

        // do K=3 N=4: three ROM words then nine cache words
        sel_issues = 0;
        step(1, 0, dw(4, 3), 0, 16'h0, 1, 0);
        for (int i = 0; i < 3; i++) issue(lit[i]);
        chk("t1_first_replay", 32'(lc.cache_dout), 32'h1111);
        for (int i = 0; i < 9; i++) begin
            chk("t1_replay_word", 32'(lc.cache_dout), 32'(lit[i % 3]));
            issue(16'hdead);
        end
        chk("t1_sel_issues", 32'(sel_issues), 32'd9);
        chk("t1_idle_after", 32'(lc.busy), 32'd0);

        // reset on the 5th replay issue
        step(1, 0, dw(4, 3), 0, 16'h0, 1, 0);
        for (int i = 0; i < 3; i++) issue(lit[i]);
        for (int i = 0; i < 4; i++) issue(16'h0);
        step(0, 0, 11'd0, 1, 16'h0, 1, 1);
        chk("t6_outputs", 32'({lc.busy, lc.no_int, lc.cache_sel, lc.pc_halt}), 32'(0));
        step(0, 1, dw(2, 0), 0, 16'h0, 1, 0);
        chk("t6_redo_ignored", 32'(lc.busy), 32'd0);

        // K=0 / N=0 and stray inst_issue in IDLE
        step(1, 0, dw(3, 0), 1, 16'h5, 1, 0);
        step(1, 0, dw(0, 3), 1, 16'h5, 1, 0);
        chk("t5_ignored", 32'(lc.busy), 32'd0);

        // do K=2 N=1: recorded but never replayed
        sel_issues = 0;
        step(1, 0, dw(1, 2), 0, 16'h0, 1, 0);
        issue(16'haaaa); issue(16'hbbbb);
        chk("t2_no_replay", 32'(sel_issues), 32'd0);
        chk("t2_idle", 32'(lc.busy), 32'd0);

        // K=15 N=2, then redo N=3 from the full cache
        step(1, 0, dw(2, 15), 0, 16'h0, 1, 0);
        drain(100);
        sel_issues = 0;
        step(0, 1, dw(3, 0), 0, 16'h0, 1, 0);
        chk("t4_redo_sel", 32'(lc.cache_sel), 32'd1);
        drain(100);
        chk("t4_sel_issues", 32'(sel_issues), 32'd45);

        // do during REPLAY ignored; do+redo together takes do
        step(1, 0, dw(3, 2), 0, 16'h0, 1, 0);
        issue(16'h1); issue(16'h2);
        step(1, 0, dw(2, 5), 0, 16'h0, 1, 0);
        drain(100);
        step(1, 1, dw(1, 2), 0, 16'h0, 1, 0);
        chk("t7_do_wins", 32'({lc.busy, lc.cache_sel}), 32'b10);
        drain(100);

        // random traffic with cen/issue gaps and occasional reset
        for (int i = 0; i < 3000; i++) begin
            int sel;
            sel = int'($urandom_range(0, 99));
            step(sel < 8, sel >= 8 && sel < 14,
                 dw(int'($urandom_range(0, 4)), int'($urandom_range(0, 15))),
                 ($urandom % 4) != 0, 16'($urandom), ($urandom % 5) != 0, sel == 99);
        end

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
